dram_port_arbiter: RTL

DRAM_PORT_ARBITER -- requirements
Module: dram_port_arbiter

---
 rtl/dram_port_arbiter.sv | 58 +++++
 1 files changed

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: shares one single-port RAM between an instruction-fetch port and a data port
module dram_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_DATA = 2'b01, OWN_FETCH = 2'b10} owner_e;
    owner_e            rsel_q, rsel_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    // arbitration, RAM command mux and next-state; grants are gated by rst so reset forces everything idle
    always_comb begin
        if_gnt    = rst && if_req && (!d_req || wcnt_q == MAX_CNT);
        d_gnt     = rst && d_req && !if_gnt;
        mem_rd    = if_gnt || (d_gnt && !d_we);
        mem_wr    = d_gnt && d_we;
        mem_addr  = if_gnt ? if_addr : d_gnt ? d_addr : 32'h0;
        mem_wdata = mem_wr ? d_wdata : 32'h0;
        mem_be    = mem_rd ? 4'hF : mem_wr ? d_be : 4'h0;
        wcnt_d    = (if_req && !if_gnt) ? (wcnt_q == MAX_CNT ? wcnt_q : wcnt_q + 1'b1) : '0;
        rsel_d    = if_gnt ? OWN_FETCH : (d_gnt && !d_we) ? OWN_DATA : OWN_NONE;
    end
    // starvation counter and read-owner register; reset drops any read still in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q <= '0;
            rsel_q <= OWN_NONE;
        end else begin
            wcnt_q <= wcnt_d;
            rsel_q <= rsel_d;
        end
    end
    assign if_rvalid = (rsel_q == OWN_FETCH);
    assign d_rvalid  = (rsel_q == OWN_DATA);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign d_rdata   = d_rvalid ? mem_rdata : 32'h0;
endmodule
